// File: rtl/deck_server_pkg.sv
// deck_server_pkg: deck constants, FSM state encoding and card scoring shared with the game FSM
package deck_server_pkg;
    localparam int          PTS_W     = 6;
    localparam logic [5:0]  DECK_SIZE = 6'd52;
    localparam logic [15:0] SEED_DFLT = 16'hACE1;

    typedef enum logic [3:0] {
        IDLE, INIT, SH_RDI, SH_RDJ, SH_WRJ, SH_WRI, SERVE, RD, UPD, ACK
    } state_t;

    // Card c in 0..51, rank = c % 13: Ace counts 1 here, 2..10 face value, J/Q/K 10.
    function automatic logic [3:0] card_value(input logic [5:0] c);
        logic [5:0] r;
        r = c % 6'd13;
        return (r == 6'd0) ? 4'd1 : (r < 6'd10) ? 4'(r + 6'd1) : 4'd10;
    endfunction
endpackage

// File: rtl/deck_server_if.sv
// deck_server_if: shuffle control, card request handshake, hand totals and deck RAM port.
// slave: deck_server side; master: game FSM / RAM side.
interface deck_server_if;
    import deck_server_pkg::*;
    logic              embaralhar_start, embaralhar_ok;
    logic              pjogador, pdealer, cartaok, deck_empty;
    logic [PTS_W-1:0]  pts_jogador, pts_dealer;
    logic [15:0]       seed;
    logic [5:0]        mem_addr, mem_wdata, mem_rdata;
    logic              mem_we;

    modport slave (
        input  embaralhar_start, pjogador, pdealer, seed, mem_rdata,
        output embaralhar_ok, cartaok, deck_empty, pts_jogador, pts_dealer,
               mem_addr, mem_we, mem_wdata
    );
    modport master (
        output embaralhar_start, pjogador, pdealer, seed, mem_rdata,
        input  embaralhar_ok, cartaok, deck_empty, pts_jogador, pts_dealer,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/deck_server_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) with seed load; a zero seed loads INIT.
// Ports: clock, reset (async, active-high), load, en, seed[15:0], q[15:0].
module lfsr16 #(
    parameter logic [15:0] INIT = 16'hACE1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] q
);
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            q <= INIT;
        else if (load)
            q <= (seed == 16'd0) ? INIT : seed;
        else if (en)
            q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    end
endmodule

// File: rtl/deck_server.sv
// deck_server: owns the deck RAM; init + Fisher-Yates shuffle, player/dealer card serving, hand totals.
// Ports: clock, reset (async, active-high), bus (deck_server_if.slave: embaralhar_start/ok, seed,
//        pjogador/pdealer/cartaok four-phase handshake, pts_jogador/pts_dealer, deck_empty,
//        mem_addr/mem_we/mem_wdata/mem_rdata to a 1-cycle sync-read RAM).
// Parameters: SHUFFLE (1: init + shuffle, 0: identity deck), SEED_DFLT (LFSR value when seed==0).
// Build option: ACE_SOFT_EN -- Ace counts 11 while that keeps the hand <=21 (soft hand).
module deck_server #(
    parameter bit          SHUFFLE   = 1'b1,
    parameter logic [15:0] SEED_DFLT = deck_server_pkg::SEED_DFLT
) (
    input logic          clock,
    input logic          reset,
    deck_server_if.slave bus
);
    import deck_server_pkg::*;

    state_t      state;
    logic [5:0]  i, ptr, j, cur, nxt;
    logic [3:0]  v;
    logic [6:0]  sum;
    logic [15:0] lfsr;
    logic        start_q, pend, sel_d, start_edge, go, unused_lfsr_hi;
`ifdef ACE_SOFT_EN
    logic        soft_j, soft_d, cur_soft, ace_hi, bust, nxt_soft;
`endif

    assign start_edge     = bus.embaralhar_start & ~start_q;
    assign go             = (start_edge & (state == IDLE)) | ((start_edge | pend) & (state == SERVE));
    assign unused_lfsr_hi = ^lfsr[15:12];
    // (lfsr[11:0] * (i+1)) >> 12 is always <= i, so j stays inside the unshuffled prefix.
    assign j = 6'(({6'd0, lfsr[11:0]} * {12'd0, i + 6'd1}) >> 12);

    lfsr16 #(.INIT(SEED_DFLT)) u_lfsr (
        .clock(clock), .reset(reset), .load(go), .en(1'b1), .seed(bus.seed), .q(lfsr)
    );

    // Next total of the granted hand for the card on mem_rdata, saturated to 6 bits.
    always_comb begin
        cur = sel_d ? bus.pts_dealer : bus.pts_jogador;
        v   = card_value(bus.mem_rdata);
`ifdef ACE_SOFT_EN
        cur_soft = sel_d ? soft_d : soft_j;
        ace_hi   = (v == 4'd1) && (cur <= 6'd10);
        sum      = {1'b0, cur} + (ace_hi ? 7'd11 : {3'd0, v});
        bust     = (sum > 7'd21) && cur_soft;
        sum      = bust ? sum - 7'd10 : sum;
        nxt_soft = ace_hi | (cur_soft & ~bust);
`else
        sum = {1'b0, cur} + {3'd0, v};
`endif
        nxt = (sum > 7'd63) ? 6'd63 : sum[5:0];
    end

    // Shuffle step order is RDI, RDJ, WRJ, WRI: d_i is on mem_rdata one cycle before d_j,
    // so writing j first lets every write use registered data straight from mem_rdata.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            i                 <= '0;
            ptr               <= '0;
            sel_d             <= 1'b0;
            pend              <= 1'b0;
            start_q           <= 1'b0;
            bus.embaralhar_ok <= 1'b0;
            bus.cartaok       <= 1'b0;
            bus.deck_empty    <= 1'b0;
            bus.pts_jogador   <= '0;
            bus.pts_dealer    <= '0;
            bus.mem_addr      <= '0;
            bus.mem_we        <= 1'b0;
            bus.mem_wdata     <= '0;
`ifdef ACE_SOFT_EN
            soft_j            <= 1'b0;
            soft_d            <= 1'b0;
`endif
        end else begin
            start_q <= bus.embaralhar_start;
            if (start_edge && (state == RD || state == UPD || state == ACK))
                pend <= 1'b1;
            if (go) begin
                state             <= INIT;
                i                 <= '0;
                ptr               <= '0;
                pend              <= 1'b0;
                bus.embaralhar_ok <= 1'b0;
                bus.deck_empty    <= 1'b0;
                bus.pts_jogador   <= '0;
                bus.pts_dealer    <= '0;
                bus.mem_addr      <= '0;
                bus.mem_wdata     <= '0;
                bus.mem_we        <= 1'b1;
`ifdef ACE_SOFT_EN
                soft_j            <= 1'b0;
                soft_d            <= 1'b0;
`endif
            end else begin
                case (state)
                    INIT: begin
                        if (i == DECK_SIZE - 6'd1) begin
                            bus.mem_we        <= 1'b0;
                            bus.embaralhar_ok <= !SHUFFLE;
                            state             <= SHUFFLE ? SH_RDI : SERVE;
                        end else begin
                            i             <= i + 6'd1;
                            bus.mem_addr  <= i + 6'd1;
                            bus.mem_wdata <= i + 6'd1;
                        end
                    end
                    SH_RDI: begin
                        bus.mem_addr <= j;
                        state        <= SH_RDJ;
                    end
                    SH_RDJ: begin
                        bus.mem_we    <= 1'b1;
                        bus.mem_wdata <= bus.mem_rdata;
                        state         <= SH_WRJ;
                    end
                    SH_WRJ: begin
                        bus.mem_addr  <= i;
                        bus.mem_wdata <= bus.mem_rdata;
                        state         <= SH_WRI;
                    end
                    SH_WRI: begin
                        bus.mem_we <= 1'b0;
                        if (i == 6'd1) begin
                            bus.mem_addr      <= '0;
                            bus.embaralhar_ok <= 1'b1;
                            state             <= SERVE;
                        end else begin
                            i            <= i - 6'd1;
                            bus.mem_addr <= i - 6'd1;
                            state        <= SH_RDI;
                        end
                    end
                    SERVE: begin
                        if (bus.pjogador || bus.pdealer) begin
                            sel_d <= !bus.pjogador;
                            if (ptr == DECK_SIZE) begin
                                bus.cartaok <= 1'b1;
                                state       <= ACK;
                            end else begin
                                bus.mem_addr <= ptr;
                                state        <= RD;
                            end
                        end
                    end
                    RD: state <= UPD;
                    UPD: begin
                        if (sel_d) bus.pts_dealer <= nxt;
                        else bus.pts_jogador <= nxt;
`ifdef ACE_SOFT_EN
                        if (sel_d) soft_d <= nxt_soft;
                        else soft_j <= nxt_soft;
`endif
                        ptr            <= ptr + 6'd1;
                        bus.deck_empty <= (ptr == DECK_SIZE - 6'd1);
                        bus.cartaok    <= 1'b1;
                        state          <= ACK;
                    end
                    ACK: begin
                        if (!(sel_d ? bus.pdealer : bus.pjogador)) begin
                            bus.cartaok <= 1'b0;
                            state       <= SERVE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_deck_server.sv
// tb_deck_server: directed bench; a shuffling instance checks permutation/determinism/reset abort,
// an identity-deck instance is checked against a card-by-card scoring model.
module tb_deck_server;
    logic clock = 1'b0;
    logic rst_s = 1'b1;
    logic rst_i = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_pj, m_pd, m_next;
    bit   m_sj, m_sd, m_empty;
    int   order [52];

`ifdef ACE_SOFT_EN
    localparam int P1 = 11, P2 = 14;
`else
    localparam int P1 = 1, P2 = 4;
`endif

    always #5 clock = ~clock;

    deck_server_if s_if ();
    deck_server_if i_if ();

    deck_server #(.SHUFFLE(1'b1)) u_shuf (.clock(clock), .reset(rst_s), .bus(s_if.slave));
    deck_server #(.SHUFFLE(1'b0)) u_id   (.clock(clock), .reset(rst_i), .bus(i_if.slave));

    logic [5:0] s_ram [64];
    logic [5:0] i_ram [64];

    always @(posedge clock) begin
        if (s_if.mem_we) s_ram[s_if.mem_addr] <= s_if.mem_wdata;
        s_if.mem_rdata <= s_ram[s_if.mem_addr];
        if (i_if.mem_we) i_ram[i_if.mem_addr] <= i_if.mem_wdata;
        i_if.mem_rdata <= i_ram[i_if.mem_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int outs(input bit on_s);
        if (on_s)
            return int'({s_if.embaralhar_ok, s_if.cartaok, s_if.deck_empty, s_if.mem_we,
                         s_if.mem_addr, s_if.mem_wdata, s_if.pts_jogador, s_if.pts_dealer});
        return int'({i_if.embaralhar_ok, i_if.cartaok, i_if.deck_empty, i_if.mem_we,
                     i_if.mem_addr, i_if.mem_wdata, i_if.pts_jogador, i_if.pts_dealer});
    endfunction

    task automatic model_reset();
        m_pj = 0; m_pd = 0; m_next = 0; m_sj = 0; m_sd = 0; m_empty = 0;
    endtask

    // Identity deck: the n-th card dealt is card n.
    task automatic model_deal(input bit dealer);
        int r, v, t;
        bit s;
        if (m_next >= 52) return;
        r = m_next % 13;
        v = (r == 0) ? 1 : (r < 10) ? r + 1 : 10;
        t = dealer ? m_pd : m_pj;
        s = dealer ? m_sd : m_sj;
`ifdef ACE_SOFT_EN
        if (v == 1 && t + 11 <= 21) begin
            v = 11;
            s = 1;
        end
        t += v;
        if (t > 21 && s) begin
            t -= 10;
            s = 0;
        end
`else
        t += v;
`endif
        if (t > 63) t = 63;
        if (dealer) begin m_pd = t; m_sd = s; end
        else begin m_pj = t; m_sj = s; end
        m_next++;
        m_empty = (m_next == 52);
    endtask

    // Totals and deck_empty are meaningful while cartaok is high.
    always @(negedge clock) begin
        if (!rst_i && i_if.cartaok === 1'b1) begin
            chk("model_pts_jogador", int'(i_if.pts_jogador), m_pj);
            chk("model_pts_dealer", int'(i_if.pts_dealer), m_pd);
            chk("model_deck_empty", int'(i_if.deck_empty), int'(m_empty));
        end
    end

    task automatic shuffle(input bit on_s, input logic [15:0] sd, output int cyc);
        if (on_s) begin s_if.seed = sd; s_if.embaralhar_start = 1'b0; end
        else begin i_if.seed = sd; i_if.embaralhar_start = 1'b0; end
        tick();
        if (on_s) s_if.embaralhar_start = 1'b1;
        else i_if.embaralhar_start = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!(on_s ? s_if.embaralhar_ok : i_if.embaralhar_ok) && cyc < 400);
        chk("embaralhar_ok_rise", int'(on_s ? s_if.embaralhar_ok : i_if.embaralhar_ok), 1);
        chk("embaralhar_ok_by_257", int'(cyc <= 257), 1);
        if (!on_s) model_reset();
    endtask

    task automatic check_perm(input string nm, input bit cmp_order);
        bit seen [52];
        int bad = 0, diff = 0;
        for (int k = 0; k < 52; k++) begin
            if (s_ram[k] >= 6'd52 || seen[s_ram[k]]) bad++;
            else seen[s_ram[k]] = 1'b1;
            if (cmp_order && order[k] != int'(s_ram[k])) diff++;
            if (!cmp_order) order[k] = int'(s_ram[k]);
        end
        chk({nm, "_perm_errors"}, bad, 0);
        if (cmp_order) chk({nm, "_order_diffs"}, diff, 0);
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (i_if.cartaok !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic req(input bit dealer);
        int n;
        bit was_empty;
        was_empty = m_empty;
        model_deal(dealer);
        if (dealer) i_if.pdealer = 1'b1;
        else i_if.pjogador = 1'b1;
        wait_ack(n);
        if (was_empty) chk("cartaok_empty_deck", int'(i_if.cartaok), 1);
        else chk("cartaok_latency", n, 3);
        i_if.pdealer = 1'b0;
        i_if.pjogador = 1'b0;
        tick();
        chk("cartaok_fall", int'(i_if.cartaok), 0);
    endtask

    initial begin
        int cyc, n, moved;
        s_if.embaralhar_start = 1'b0; s_if.pjogador = 1'b0; s_if.pdealer = 1'b0; s_if.seed = '0;
        i_if.embaralhar_start = 1'b0; i_if.pjogador = 1'b0; i_if.pdealer = 1'b0; i_if.seed = '0;
        s_if.mem_rdata = '0;
        i_if.mem_rdata = '0;
        model_reset();
        repeat (3) tick();
        chk("reset_outputs_shuf", outs(1'b1), 0);
        chk("reset_outputs_id", outs(1'b0), 0);
        rst_s = 1'b0;
        rst_i = 1'b0;
        tick();

        // Shuffle with seed 1234: permutation, not identity, reproducible.
        shuffle(1'b1, 16'h1234, cyc);
        check_perm("shuffle1", 1'b0);
        moved = 0;
        for (int k = 0; k < 52; k++) if (order[k] != k) moved++;
        chk("shuffle_moved_cards", int'(moved > 0), 1);
        shuffle(1'b1, 16'h1234, cyc);
        check_perm("shuffle_rerun", 1'b1);

        // Reset in the middle of a shuffle, then a fresh shuffle with the same seed.
        s_if.embaralhar_start = 1'b0;
        tick();
        s_if.embaralhar_start = 1'b1;
        repeat (100) tick();
        rst_s = 1'b1;
        #1;
        chk("reset_midshuffle_outputs", outs(1'b1), 0);
        tick();
        s_if.embaralhar_start = 1'b0;
        rst_s = 1'b0;
        tick();
        shuffle(1'b1, 16'h1234, cyc);
        check_perm("shuffle_after_reset", 1'b1);

        // Identity deck: P, D, P, D.
        shuffle(1'b0, 16'h0000, cyc);
        n = 0;
        for (int k = 0; k < 52; k++) if (int'(i_ram[k]) != k) n++;
        chk("identity_deck_errors", n, 0);
        req(1'b0);
        chk("pdpd_jogador_1", int'(i_if.pts_jogador), P1);
        req(1'b1);
        chk("pdpd_dealer_1", int'(i_if.pts_dealer), 2);
        req(1'b0);
        chk("pdpd_jogador_2", int'(i_if.pts_jogador), P2);
        req(1'b1);
        chk("pdpd_dealer_2", int'(i_if.pts_dealer), 6);

        // Both requests in the same cycle: player first, dealer after the handshake.
        shuffle(1'b0, 16'h0000, cyc);
        chk("restart_totals", int'({i_if.pts_jogador, i_if.pts_dealer}), 0);
        model_deal(1'b0);
        i_if.pjogador = 1'b1;
        i_if.pdealer = 1'b1;
        wait_ack(n);
        chk("both_latency", n, 3);
        chk("both_player_first", int'(i_if.pts_jogador), P1);
        chk("both_dealer_waits", int'(i_if.pts_dealer), 0);
        i_if.pjogador = 1'b0;
        tick();
        chk("both_cartaok_fall", int'(i_if.cartaok), 0);
        model_deal(1'b1);
        wait_ack(n);
        chk("both_dealer_served", int'(i_if.cartaok), 1);
        chk("both_dealer_card1", int'(i_if.pts_dealer), 2);
        i_if.pdealer = 1'b0;
        tick();
        chk("both_dealer_fall", int'(i_if.cartaok), 0);

        // Deal the whole deck to the player, then one more request.
        shuffle(1'b0, 16'h0000, cyc);
        for (int k = 0; k < 52; k++) req(1'b0);
        chk("empty_flag", int'(i_if.deck_empty), 1);
        chk("empty_pts_saturated", int'(i_if.pts_jogador), 63);
        req(1'b0);
        chk("empty_extra_pts", int'(i_if.pts_jogador), 63);
        chk("empty_extra_dealer", int'(i_if.pts_dealer), 0);
        chk("empty_flag_held", int'(i_if.deck_empty), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
